img_frame_sched: RTL
====================

Name: img_frame_sched

Overview:
- Frame-level sequencer between the image ROM streamer and the MNIST CNN classifier.
- On a trigger, or continuously in auto mode:
  - selects an image slot and pulses the streamer's start;
  - counts the delivered pixels;
  - waits for the classifier verdict, then latches the class and a frame count.
- Also flags protocol errors (stray or excess pixels, and classifier timeout when the optional feature is compiled in).

Parameters:
- TOTAL_BYTES, 784, pixels per frame expected from the streamer.
- NUM_IMGS, 10, number of image slots; img_sel wraps modulo NUM_IMGS.
- SEL_W, 4, width of img_sel (must satisfy 2^SEL_W >= NUM_IMGS).
- GAP_CYCLES, 1000, idle cycles between frames in auto mode (>=1).
- TIMEOUT_CYCLES, 65535, maximum cycles in WAIT_RES (only used with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- trig  in  1  one-cycle request to run one frame; sampled only in IDLE.
- auto_en  in  1  level; 1 = after each frame, run the next slot after GAP_CYCLES.
- pix_vld  in  1  pixel-valid strobe from the image streamer.
- res_vld  in  1  classifier result strobe.
- res_class  in  4  classifier digit, valid with res_vld.
- img_start  out  1  one-cycle start pulse to the streamer.
- img_sel  out  SEL_W  current image slot index.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a result is captured.
- result  out  4  last captured class.
- frame_cnt  out  16  completed frames; wraps 0xFFFF->0.
- err_pix  out  1  sticky: pix_vld outside STREAM, or more than TOTAL_BYTES pixels seen.
- err_tmo  out  1  sticky: classifier timeout (tied 0 without the optional feature).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE;
  - every output is 0, including img_sel, result, frame_cnt and both sticky errors;
  - internal counters are cleared;
  - reset mid-frame abandons the frame with no frame_done.
- State machine (registered outputs):
  - IDLE: if trig=1, or a pending auto restart exists, go to START. Otherwise stay.
  - START: img_start=1 for exactly this cycle; pix_cnt cleared; next state STREAM.
  - STREAM:
    - each pix_vld increments pix_cnt;
    - the cycle pix_cnt reaches TOTAL_BYTES (the TOTAL_BYTES-th pix_vld), go to WAIT_RES;
    - no timeout applies in STREAM.
  - WAIT_RES: on res_vld, capture result<=res_class, increment frame_cnt, and go to DONE. Both registered values update in the cycle after res_vld.
  - DONE:
    - frame_done=1 for one cycle;
    - img_sel advances: NUM_IMGS-1 wraps to 0;
    - if auto_en=1, go to GAP; otherwise go to IDLE.
  - GAP:
    - count GAP_CYCLES cycles, then go to START;
    - if auto_en drops during GAP, go to IDLE on the next cycle with no start.
- Latency:
  - trig -> img_start: 2 cycles (IDLE->START transition plus the registered output).
  - res_vld -> frame_done: 2 cycles.
- Boundaries:
  - trig while busy is ignored; it is not queued.
  - res_vld outside WAIT_RES is ignored and is not an error.
  - pix_vld in any state other than STREAM (including WAIT_RES, i.e. an excess pixel) sets err_pix. The state is unaffected.
  - res_vld in the same cycle as the final pixel is ignored, because the state is still STREAM.
  - err_pix and err_tmo clear only on reset.
  - frame_cnt wraps silently.

Optional Feature:
- Macro: IMG_FRAME_SCHED_TIMEOUT_EN.
- Defined:
  - a 16-bit watchdog counts cycles in WAIT_RES;
  - if it reaches TIMEOUT_CYCLES without res_vld: err_tmo<=1, result<=4'hF, frame_cnt is not incremented, and the FSM goes to DONE;
  - frame_done pulses and img_sel advances as normal.
- Undefined: no watchdog logic; err_tmo is tied to 0; WAIT_RES waits indefinitely.

Test Plan (TOTAL_BYTES=4, NUM_IMGS=3, GAP_CYCLES=5, TIMEOUT_CYCLES=20):
1. Reset, then trig at cycle 0 -> img_start high at cycle 2 only. Feed 4 pix_vld, then res_vld with res_class=7 -> frame_done one cycle, result=7, frame_cnt=1, img_sel=1, busy=0 afterwards.
2. auto_en=1, one trig, classifier answers 3,5,9 -> three frames, each frame_done followed by a start after the gap; img_sel sequence 0->1->2->0; frame_cnt=3.
3. trig pulsed during STREAM, and pix_vld pulsed in IDLE -> no extra img_start; err_pix=1 from the IDLE pixel and stays 1 until reset.
4. Five pix_vld in one frame -> FSM in WAIT_RES after the 4th; 5th sets err_pix; a later res_vld with res_class=2 still completes with result=2.
5. With IMG_FRAME_SCHED_TIMEOUT_EN, no res_vld after 4 pixels -> after 20 cycles err_tmo=1, result=0xF, frame_done pulses, frame_cnt unchanged. Without the macro -> FSM stays in WAIT_RES and err_tmo=0.
6. rst_n=0 for one cycle while in STREAM with pix_cnt=2 -> all outputs 0, state IDLE, no frame_done; a fresh trig then runs a full frame normally.

Source files
------------

// File: rtl/img_frame_sched.sv
// img_frame_sched
//   Frame-level sequencer between the image ROM streamer and the MNIST CNN
//   classifier. A trig, or auto mode, picks the current image slot and pulses
//   the streamer start. It then counts TOTAL_BYTES pixels and waits for the
//   classifier verdict. The class is latched, frame_cnt is bumped, and the
//   slot index advances.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   trig        in   one-cycle frame request, honoured only in IDLE
//   auto_en     in   level, chain frames separated by GAP_CYCLES idle cycles
//   pix_vld     in   pixel strobe from the streamer
//   res_vld     in   classifier result strobe
//   res_class   in   classifier digit, valid with res_vld
//   img_start   out  one-cycle streamer start pulse
//   img_sel     out  current image slot (wraps modulo NUM_IMGS)
//   busy        out  high whenever the FSM is not in IDLE
//   frame_done  out  one-cycle pulse after a verdict (or timeout) is captured
//   result      out  last captured class (4'hF after a timeout)
//   frame_cnt   out  completed frames, wraps silently
//   err_pix     out  sticky, pixel outside STREAM or excess pixel
//   err_tmo     out  sticky, classifier timeout
//
// Build option
//   IMG_FRAME_SCHED_TIMEOUT_EN : adds the WAIT_RES watchdog. Without it,
//   err_tmo is tied low and WAIT_RES waits indefinitely.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for trig
// START    | clear pixel count; img_start is raised on the following cycle
// STREAM   | counting pixels until TOTAL_BYTES have arrived
// WAIT_RES | waiting for the classifier verdict (watchdog when enabled)
// DONE     | advance img_sel; frame_done is raised on the following cycle
// GAP      | auto mode inter-frame delay (down-counter)

module img_frame_sched #(
  parameter int unsigned TOTAL_BYTES    = 784,
  parameter int unsigned NUM_IMGS       = 10,
  parameter int unsigned SEL_W          = 4,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             auto_en,
  input  logic             pix_vld,
  input  logic             res_vld,
  input  logic [3:0]       res_class,
  output logic             img_start,
  output logic [SEL_W-1:0] img_sel,
  output logic             busy,
  output logic             frame_done,
  output logic [3:0]       result,
  output logic [15:0]      frame_cnt,
  output logic             err_pix,
  output logic             err_tmo
);

  localparam int unsigned PIX_W = $clog2(TOTAL_BYTES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TOTAL_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IMGS - 1);

  // Elaboration-time sanity checks on the configuration.
  if ((2 ** SEL_W) < NUM_IMGS) begin : g_bad_sel_w
    $error("img_frame_sched: SEL_W too narrow for NUM_IMGS");
  end
  if (GAP_CYCLES < 1 || TOTAL_BYTES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("img_frame_sched: illegal GAP_CYCLES/TOTAL_BYTES/TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [PIX_W-1:0] pix_cnt, pix_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             res_take;
  logic             tmo_hit;

  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    gap_cnt_nxt = gap_cnt;
    res_take    = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig) state_nxt = S_START;
      end
      S_START: begin
        pix_cnt_nxt = '0;
        state_nxt   = S_STREAM;
      end
      S_STREAM: begin
        if (pix_vld) begin
          pix_cnt_nxt = pix_cnt + 1'b1;
          if (pix_cnt == PIX_LAST) state_nxt = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (res_vld) begin
          res_take  = 1'b1;
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (auto_en) begin
          gap_cnt_nxt = GAP_LOAD;
          state_nxt   = S_GAP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        // Dropping auto_en wins over the terminal count: no late start.
        if (!auto_en)            state_nxt   = S_IDLE;
        else if (gap_cnt == '0)  state_nxt   = S_START;
        else                     gap_cnt_nxt = gap_cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      gap_cnt    <= '0;
      img_start  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      img_sel    <= '0;
      result     <= '0;
      frame_cnt  <= '0;
      err_pix    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      // Pulses lag the state by one cycle; busy tracks the state itself.
      img_start  <= (state == S_START);
      frame_done <= (state == S_DONE);
      busy       <= (state_nxt != S_IDLE);
      if (state == S_DONE) begin
        img_sel <= (img_sel == SEL_LAST) ? '0 : img_sel + 1'b1;
      end
      if (res_take) begin
        result    <= res_class;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (tmo_hit) begin
        result <= 4'hF;
      end
      if (pix_vld && (state != S_STREAM)) err_pix <= 1'b1;
    end
  end

`ifdef IMG_FRAME_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdg_cnt, wdg_nxt;

  // Held at the load value through STREAM so it is primed on entry to
  // WAIT_RES; reaching zero there means TIMEOUT_CYCLES cycles without res_vld.
  always_comb begin
    wdg_nxt = wdg_cnt;
    tmo_hit = 1'b0;
    if (state == S_STREAM) begin
      wdg_nxt = TMO_LOAD;
    end else if ((state == S_WAIT_RES) && !res_vld) begin
      if (wdg_cnt == 16'd0) tmo_hit = 1'b1;
      else                  wdg_nxt = wdg_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdg_cnt <= 16'd0;
      err_tmo <= 1'b0;
    end else begin
      wdg_cnt <= wdg_nxt;
      if (tmo_hit) err_tmo <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

endmodule
